// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and constants for the multicycle controller
// Purpose: state encoding, opcode/funct constants, aluop codes, the
//          per-state control word and the Moore output table.
// Ports:   none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output table: the control word belonging to each state.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU operation decoder
// Purpose: maps aluop and the R-type funct field to the 3-bit ALU control.
// Ports:   funct (6b in), aluop (2b in), alucontrol (3b out).
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_ADD:  alucontrol = 3'b010;
      ALUOP_SUB:  alucontrol = 3'b110;
      ALUOP_ADD2: alucontrol = 3'b010;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = 3'b010;
          FN_SUB:  alucontrol = 3'b110;
          FN_AND:  alucontrol = 3'b000;
          FN_OR:   alucontrol = 3'b001;
          FN_SLT:  alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle processor control FSM
// Purpose: Moore FSM sequencing fetch/decode/execute/memory/writeback with
//          registered per-state control outputs, pcen generation and ALU decode.
// Ports:   clk, reset (async, active-low), op, funct, zero in;
//          pcen, irwrite, regwrite, memwrite (enables), alusrca, iord,
//          memtoreg, regdst, alusrcb, pcsrc (selects), alucontrol, state_dbg out.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_dbg
);

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_next;

  // op only matters when leaving DECODE or MEMADR.
  function automatic state_t next_state(input state_t s, input logic [5:0] opc);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BEQ;
          OP_ADDI:      n = S_ADDIEXEC;
          OP_J:         n = S_JUMP;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:   n = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    n = S_MEMWB;
      S_EXECUTE:  n = S_ALUWB;
      S_ADDIEXEC: n = S_ADDIWB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  assign w_next = next_state(r_state, op);

  // Control word is registered together with the state so outputs come
  // straight from flops; it always equals ctrl_for(r_state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_for(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for(w_next);
    end
  end

  // Write enables are gated by reset so nothing writes while reset is low,
  // yet FETCH takes effect as soon as reset releases.
  assign pcen      = reset & (r_ctrl.pcwrite | (r_ctrl.branch & zero));
  assign irwrite   = reset & r_ctrl.irwrite;
  assign regwrite  = reset & r_ctrl.regwrite;
  assign memwrite  = reset & r_ctrl.memwrite;
  assign alusrca   = r_ctrl.alusrca;
  assign iord      = r_ctrl.iord;
  assign memtoreg  = r_ctrl.memtoreg;
  assign regdst    = r_ctrl.regdst;
  assign alusrcb   = r_ctrl.alusrcb;
  assign pcsrc     = r_ctrl.pcsrc;
  assign state_dbg = r_state;

  aludec u_aludec (
    .funct      (funct),
    .aluop      (r_ctrl.aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite;
  logic       alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic scramble = 1'b0;

  // {state, pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
  //  regdst, alusrcb, pcsrc, alucontrol}
  logic [18:0] obs;
  assign obs = {state_dbg, pcen, irwrite, regwrite, memwrite,
                alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol};

  localparam logic [18:0] V_RST   = 19'b0000_0000_0000_01_00_010;
  localparam logic [18:0] V_FETCH = 19'b0000_1100_0000_01_00_010;
  localparam logic [18:0] V_DEC   = 19'b0001_0000_0000_11_00_010;
  localparam logic [18:0] V_MADR  = 19'b0010_0000_1000_10_00_010;
  localparam logic [18:0] V_MRD   = 19'b0011_0000_0100_00_00_010;
  localparam logic [18:0] V_MWB   = 19'b0100_0010_0010_00_00_010;
  localparam logic [18:0] V_MWR   = 19'b0101_0001_0100_00_00_010;
  localparam logic [18:0] V_EXSLT = 19'b0110_0000_1000_00_00_111;
  localparam logic [18:0] V_EXSUB = 19'b0110_0000_1000_00_00_110;
  localparam logic [18:0] V_EXUNK = 19'b0110_0000_1000_00_00_010;
  localparam logic [18:0] V_ALUWB = 19'b0111_0010_0001_00_00_010;
  localparam logic [18:0] V_BEQ0  = 19'b1000_0000_1000_00_01_110;
  localparam logic [18:0] V_BEQ1  = 19'b1000_1000_1000_00_01_110;
  localparam logic [18:0] V_AEX   = 19'b1001_0000_1000_10_00_010;
  localparam logic [18:0] V_AWB   = 19'b1010_0010_0000_00_00_010;
  localparam logic [18:0] V_JMP   = 19'b1011_1000_0000_00_10_010;

  logic [18:0] exp_q [6];

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Checks the current cycle against exp_q[0], then one cycle per entry.
  task automatic run_seq(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      check($sformatf("%s[%0d]", tag, i), {13'd0, obs}, {13'd0, exp_q[i]});
      if (scramble && i == 3) op = 6'b000100;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset[%0d]", i), {13'd0, obs}, {13'd0, V_RST});
    end
    reset = 1'b1;
    #1;
    check("first_fetch", {13'd0, obs}, {13'd0, V_FETCH});

    // lw, with op changed after MEMADR to show it is ignored later
    op = 6'b100011; scramble = 1'b1;
    exp_q = '{V_FETCH, V_DEC, V_MADR, V_MRD, V_MWB, V_FETCH};
    run_seq("lw", 6);
    scramble = 1'b0;

    op = 6'b101011;
    exp_q = '{V_FETCH, V_DEC, V_MADR, V_MWR, V_FETCH, 19'd0};
    run_seq("sw", 5);

    op = 6'b000000; funct = 6'b101010;
    exp_q = '{V_FETCH, V_DEC, V_EXSLT, V_ALUWB, V_FETCH, 19'd0};
    run_seq("slt", 5);

    funct = 6'b100010;
    exp_q = '{V_FETCH, V_DEC, V_EXSUB, V_ALUWB, V_FETCH, 19'd0};
    run_seq("sub", 5);

    funct = 6'b111111;
    exp_q = '{V_FETCH, V_DEC, V_EXUNK, V_ALUWB, V_FETCH, 19'd0};
    run_seq("rfunk", 5);

    op = 6'b001000; funct = 6'b100010;
    exp_q = '{V_FETCH, V_DEC, V_AEX, V_AWB, V_FETCH, 19'd0};
    run_seq("addi", 5);

    op = 6'b000100; zero = 1'b1;
    exp_q = '{V_FETCH, V_DEC, V_BEQ1, V_FETCH, 19'd0, 19'd0};
    run_seq("beq_z1", 4);

    zero = 1'b0;
    exp_q = '{V_FETCH, V_DEC, V_BEQ0, V_FETCH, 19'd0, 19'd0};
    run_seq("beq_z0", 4);

    op = 6'b000010;
    exp_q = '{V_FETCH, V_DEC, V_JMP, V_FETCH, 19'd0, 19'd0};
    run_seq("j", 4);

    op = 6'b111111;
    exp_q = '{V_FETCH, V_DEC, V_FETCH, 19'd0, 19'd0, 19'd0};
    run_seq("undef", 3);

    // reset in the middle of MEMWR
    op = 6'b101011;
    exp_q = '{V_FETCH, V_DEC, V_MADR, V_MWR, 19'd0, 19'd0};
    run_seq("sw_abort", 4);
    #1;
    reset = 1'b0;
    #1;
    check("abort_now", {13'd0, obs}, {13'd0, V_RST});
    tick();
    check("abort_hold", {13'd0, obs}, {13'd0, V_RST});
    reset = 1'b1;
    #1;
    check("abort_release", {13'd0, obs}, {13'd0, V_FETCH});

    op = 6'b100011;
    exp_q = '{V_FETCH, V_DEC, V_MADR, V_MRD, V_MWB, V_FETCH};
    run_seq("lw_after", 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low; asserted when 0.
REQ-003 SHALL have port op, input, 6 bits: instr[31:26] from the datapath.
REQ-004 SHALL have port funct, input, 6 bits: instr[5:0] from the datapath.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag from the datapath.
REQ-006 SHALL have ports pcen, irwrite, regwrite, memwrite, output, 1 bit each: write enables.
REQ-007 SHALL have ports alusrca, iord, memtoreg, regdst, output, 1 bit each: mux selects.
REQ-008 SHALL have ports alusrcb and pcsrc, output, 2 bits each: mux selects.
REQ-009 SHALL have port alucontrol, output, 3 bits: ALU operation.
REQ-010 SHALL have port state_dbg, output, 4 bits: current state encoding.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-012 SHALL use these transitions:
 - FETCH->DECODE.
 - DECODE-> by op: 100011/101011 (lw/sw) MEMADR; 000000 EXECUTE; 000100 BEQ; 001000 ADDIEXEC; 000010 JUMP; any other op FETCH.
 - MEMADR-> MEMRD if op=lw, else MEMWR.
 - MEMRD->MEMWB.
 - EXECUTE->ALUWB.
 - ADDIEXEC->ADDIWB.
 - MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP->FETCH.
 - Unused encodings 12-15->FETCH.
REQ-013 SHALL drive these per-state outputs; every unlisted signal is 0:
 - FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1.
 - DECODE: alusrcb=11, aluop=00.
 - MEMADR, ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
 - MEMRD: iord=1.
 - MEMWB: memtoreg=1, regwrite=1.
 - MEMWR: iord=1, memwrite=1.
 - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
 - ALUWB: regdst=1, regwrite=1.
 - BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1.
 - ADDIWB: regwrite=1.
 - JUMP: pcsrc=10, pcwrite=1.
REQ-014 SHALL compute pcen = pcwrite | (branch & zero) combinationally in the same cycle; zero has no effect outside BEQ.
REQ-015 SHALL decode alucontrol combinationally from aluop and funct:
 - aluop 00 -> 010; aluop 01 -> 110; aluop 11 -> 010.
 - aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 010.
REQ-016 SHALL give these cycle counts, FETCH to FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, undefined op 2 (no register, memory or extra PC write).
REQ-017 SHALL sample op only in DECODE and MEMADR; op changes in other states SHALL NOT alter control.
REQ-018 SHALL drive state_dbg with the REQ-011 encoding of the current state.

Reset
REQ-019 SHALL force the state to FETCH immediately when reset=0, independent of clk.
REQ-020 SHALL hold pcen, irwrite, regwrite and memwrite at 0 while reset=0; all other outputs follow FETCH values.
REQ-021 SHALL abandon any in-progress instruction when reset asserts mid-operation, with no partial write after deassertion.
REQ-022 SHALL perform the first FETCH (irwrite=1, pcen=1) in the cycle after reset deasserts, and advance to DECODE on the following rising edge.

Structure
REQ-023 SHALL take from shared package mc_pkg: the state enum (4-bit), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, and the 2-bit aluop constants.
REQ-024 SHALL place the REQ-015 decode in sub-module aludec (inputs funct, aluop; output alucontrol); the FSM and pcen logic stay in mc_controller.

Verification
REQ-025 Bench SHALL check: reset=0 for 3 cycles, then released -> state_dbg=0 with pcen=irwrite=0 during reset; pcen=irwrite=1 in the first cycle after release.
REQ-026 Bench SHALL check: op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 in states 3-4 only where specified.
REQ-027 Bench SHALL check: op=000000 with funct=101010 -> states 0,1,6,7,0; alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-028 Bench SHALL check: op=000100 -> state 8 has pcsrc=01 and alucontrol=110; pcen=1 with zero=1 and pcen=0 with zero=0.
REQ-029 Bench SHALL check: op=000010 -> states 0,1,11,0 with pcsrc=10 and pcen=1 in state 11; op=111111 -> states 0,1,0 with no enable asserted in DECODE.
REQ-030 Bench SHALL check: reset asserted during MEMWR -> memwrite drops to 0 within the same cycle and state_dbg=0.
